// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: CPU, external master and memory buses around the data memory arbiter
interface data_mem_arbiter_if #(parameter int N = 32);
  logic         cpu_re_i;
  logic         cpu_we_i;
  logic [N-1:0] cpu_addr_i;
  logic [N-1:0] cpu_wdata_i;
  logic [N-1:0] cpu_rdata_o;
  logic         cpu_stall_o;
  logic         ext_req_i;
  logic         ext_we_i;
  logic [N-1:0] ext_addr_i;
  logic [N-1:0] ext_wdata_i;
  logic         ext_gnt_o;
  logic         ext_rvalid_o;
  logic [N-1:0] ext_rdata_o;
  logic [N-1:0] mem_addr_o;
  logic [N-1:0] mem_wdata_o;
  logic         mem_we_o;
  logic [N-1:0] mem_rdata_i;
  modport slave (
    input  cpu_re_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  ext_req_i, ext_we_i, ext_addr_i, ext_wdata_i,
    input  mem_rdata_i,
    output cpu_rdata_o, cpu_stall_o,
    output ext_gnt_o, ext_rvalid_o, ext_rdata_o,
    output mem_addr_o, mem_wdata_o, mem_we_o
  );
  modport master (
    output cpu_re_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output ext_req_i, ext_we_i, ext_addr_i, ext_wdata_i,
    output mem_rdata_i,
    input  cpu_rdata_o, cpu_stall_o,
    input  ext_gnt_o, ext_rvalid_o, ext_rdata_o,
    input  mem_addr_o, mem_wdata_o, mem_we_o
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares a single-port data memory between the CPU MEM stage and an external master
module data_mem_arbiter #(
  parameter int N          = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic              CLK,
  input logic              RST,
  data_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CPU_RD, EXT_RD} state_t;
  localparam logic [2:0] LAT  = 3'(MEM_LAT);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  state_t       state_q, state_d;
  logic [2:0]   lat_q, lat_d;
  logic [3:0]   wait_q, wait_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [N-1:0] ext_rdata_q, ext_rdata_d;
  logic         cpu_req, ext_win, done;
  // Arbitration in IDLE, read sequencing in CPU_RD/EXT_RD; reset blanks every output
  always_comb begin
    cpu_req          = bus.cpu_re_i | bus.cpu_we_i;
    ext_win          = state_q == IDLE && bus.ext_req_i && (!cpu_req || wait_q == SMAX);
    done             = lat_q == LAT;
    state_d          = state_q;
    lat_d            = lat_q + 3'd1;
    addr_d           = addr_q;
    cpu_rdata_d      = cpu_rdata_q;
    ext_rdata_d      = ext_rdata_q;
    wait_d           = !bus.ext_req_i || ext_win ? 4'd0 : wait_q == SMAX ? SMAX : wait_q + 4'd1;
    bus.mem_addr_o   = addr_q;
    bus.mem_wdata_o  = '0;
    bus.mem_we_o     = 1'b0;
    bus.cpu_stall_o  = 1'b0;
    bus.cpu_rdata_o  = cpu_rdata_q;
    bus.ext_gnt_o    = 1'b0;
    bus.ext_rvalid_o = 1'b0;
    bus.ext_rdata_o  = ext_rdata_q;
    case (state_q)
      IDLE: begin
        if (ext_win) begin
          bus.ext_gnt_o   = 1'b1;
          bus.mem_addr_o  = bus.ext_addr_i;
          bus.mem_wdata_o = bus.ext_wdata_i;
          bus.mem_we_o    = bus.ext_we_i;
          bus.cpu_stall_o = cpu_req;
          if (!bus.ext_we_i) begin
            state_d = EXT_RD;
            lat_d   = 3'd1;
            addr_d  = bus.ext_addr_i;
          end
        end else if (cpu_req) begin
          bus.mem_addr_o  = bus.cpu_addr_i;
          bus.mem_wdata_o = bus.cpu_wdata_i;
          bus.mem_we_o    = bus.cpu_we_i;
          if (!bus.cpu_we_i) begin
            bus.cpu_stall_o = 1'b1;
            state_d         = CPU_RD;
            lat_d           = 3'd1;
            addr_d          = bus.cpu_addr_i;
          end
        end
      end
      CPU_RD: begin
        bus.cpu_stall_o = !done;
        if (done) begin
          bus.cpu_rdata_o = bus.mem_rdata_i;
          cpu_rdata_d     = bus.mem_rdata_i;
          state_d         = IDLE;
        end
      end
      EXT_RD: begin
        bus.cpu_stall_o = cpu_req;
        if (done) begin
          bus.ext_rvalid_o = 1'b1;
          bus.ext_rdata_o  = bus.mem_rdata_i;
          ext_rdata_d      = bus.mem_rdata_i;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (RST) begin
      bus.mem_addr_o   = '0;
      bus.mem_wdata_o  = '0;
      bus.mem_we_o     = 1'b0;
      bus.cpu_stall_o  = 1'b0;
      bus.cpu_rdata_o  = '0;
      bus.ext_gnt_o    = 1'b0;
      bus.ext_rvalid_o = 1'b0;
      bus.ext_rdata_o  = '0;
    end
  end
  // State, counters, latched address and held read data
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      wait_q      <= '0;
      addr_q      <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      wait_q      <= wait_d;
      addr_q      <= addr_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: two arbiters (MEM_LAT 3 and 1) on shared stimulus, checked against a transaction-level model
module tb_data_mem_arbiter;
  localparam int SM = 4;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  data_mem_arbiter_if #(.N(32)) b0();
  data_mem_arbiter_if #(.N(32)) b1();
  data_mem_arbiter #(.N(32), .MEM_LAT(3), .STARVE_MAX(SM)) dut0 (.CLK(CLK), .RST(RST), .bus(b0));
  data_mem_arbiter #(.N(32), .MEM_LAT(1), .STARVE_MAX(SM)) dut1 (.CLK(CLK), .RST(RST), .bus(b1));
  assign b1.cpu_re_i    = b0.cpu_re_i;
  assign b1.cpu_we_i    = b0.cpu_we_i;
  assign b1.cpu_addr_i  = b0.cpu_addr_i;
  assign b1.cpu_wdata_i = b0.cpu_wdata_i;
  assign b1.ext_req_i   = b0.ext_req_i;
  assign b1.ext_we_i    = b0.ext_we_i;
  assign b1.ext_addr_i  = b0.ext_addr_i;
  assign b1.ext_wdata_i = b0.ext_wdata_i;

  logic [31:0] m_addr[2], m_wd[2], o_crd[2], o_erd[2];
  logic        m_we[2], o_stall[2], o_gnt[2], o_rv[2];
  always_comb begin
    m_addr[0] = b0.mem_addr_o;  m_addr[1] = b1.mem_addr_o;
    m_wd[0]   = b0.mem_wdata_o; m_wd[1]   = b1.mem_wdata_o;
    m_we[0]   = b0.mem_we_o;    m_we[1]   = b1.mem_we_o;
    o_crd[0]  = b0.cpu_rdata_o; o_crd[1]  = b1.cpu_rdata_o;
    o_erd[0]  = b0.ext_rdata_o; o_erd[1]  = b1.ext_rdata_o;
    o_stall[0] = b0.cpu_stall_o; o_stall[1] = b1.cpu_stall_o;
    o_gnt[0]  = b0.ext_gnt_o;   o_gnt[1]  = b1.ext_gnt_o;
    o_rv[0]   = b0.ext_rvalid_o; o_rv[1]  = b1.ext_rvalid_o;
  end

  function automatic logic [31:0] seed(int i);
    return 32'hA5A50000 | 32'(i);
  endfunction

  // memories with read latency 3 (dut0) and 1 (dut1)
  logic [31:0] mem [2][256];
  logic [31:0] pipe [2][3];
  logic        init_done = 1'b0;
  always @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (!init_done)
        for (int i = 0; i < 256; i++) mem[k][i] <= seed(i);
      else if (m_we[k])
        mem[k][m_addr[k][7:0]] <= m_wd[k];
      pipe[k][0] <= mem[k][m_addr[k][7:0]];
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
    init_done <= 1'b1;
  end
  assign b0.mem_rdata_i = pipe[0][2];
  assign b1.mem_rdata_i = pipe[1][0];

  // reference model: pending transaction, its age, starvation count, held read data, word store
  int          busy[2], age[2], wt[2];
  logic [31:0] baddr[2], chold[2], ehold[2];
  logic [31:0] rmem [2][256];
  int total = 0;
  int bad = 0;

  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s lat%0d got=%h want=%h t=%0t", tag, k ? 1 : 3, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    int          nb[2], na_age[2], nw[2];
    logic [31:0] na[2], nch[2], neh[2], wa[2], wd[2];
    logic        wr[2];
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      int          lat;
      logic        creq, ewin, done, xwe, xst, xgnt, xrv, iss;
      logic [31:0] xa, xwd, xcrd, xerd;
      lat  = k ? 1 : 3;
      creq = b0.cpu_re_i | b0.cpu_we_i;
      ewin = 0; done = 0; xwe = 0; xst = 0; xgnt = 0; xrv = 0; iss = 0;
      xa = baddr[k]; xwd = 0; xcrd = chold[k]; xerd = ehold[k];
      nb[k] = busy[k]; na_age[k] = age[k] + 1; na[k] = baddr[k];
      nch[k] = chold[k]; neh[k] = ehold[k]; nw[k] = 0; wr[k] = 0; wa[k] = 0; wd[k] = 0;
      if (RST) begin
        xcrd = 0; xerd = 0; nb[k] = 0; na_age[k] = 0; na[k] = 0; nch[k] = 0; neh[k] = 0;
      end else begin
        if (busy[k] == 0) begin
          ewin = b0.ext_req_i && (!creq || wt[k] == SM);
          if (ewin) begin
            iss = 1; xgnt = 1; xa = b0.ext_addr_i; xst = creq;
            if (b0.ext_we_i) begin xwe = 1; xwd = b0.ext_wdata_i; end
            else begin nb[k] = 2; na_age[k] = 1; na[k] = xa; end
          end else if (creq) begin
            iss = 1; xa = b0.cpu_addr_i;
            if (b0.cpu_we_i) begin xwe = 1; xwd = b0.cpu_wdata_i; end
            else begin xst = 1; nb[k] = 1; na_age[k] = 1; na[k] = xa; end
          end
        end else begin
          iss = 1;
          done = age[k] == lat;
          if (busy[k] == 1) begin
            xst = !done;
            if (done) begin xcrd = rmem[k][baddr[k][7:0]]; nch[k] = xcrd; end
          end else begin
            xst = creq;
            if (done) begin xrv = 1; xerd = rmem[k][baddr[k][7:0]]; neh[k] = xerd; end
          end
          if (done) nb[k] = 0;
        end
        nw[k] = (!b0.ext_req_i || xgnt) ? 0 : (wt[k] < SM ? wt[k] + 1 : SM);
        wr[k] = xwe; wa[k] = xa; wd[k] = xwd;
      end
      chk("stall", k, 32'(o_stall[k]), 32'(xst));
      chk("gnt", k, 32'(o_gnt[k]), 32'(xgnt));
      chk("rvalid", k, 32'(o_rv[k]), 32'(xrv));
      chk("mem_we", k, 32'(m_we[k]), 32'(xwe));
      chk("cpu_rdata", k, o_crd[k], xcrd);
      chk("ext_rdata", k, o_erd[k], xerd);
      if (iss) chk("mem_addr", k, m_addr[k], xa);
      if (xwe) chk("mem_wdata", k, m_wd[k], xwd);
    end
    @(posedge CLK);
    for (int k = 0; k < 2; k++) begin
      busy[k] = nb[k]; age[k] = na_age[k]; baddr[k] = na[k]; wt[k] = nw[k];
      chold[k] = nch[k]; ehold[k] = neh[k];
      if (wr[k]) rmem[k][wa[k][7:0]] = wd[k];
    end
    #1;
  endtask

  task automatic set_cpu(logic re, logic we, logic [31:0] a, logic [31:0] d);
    b0.cpu_re_i = re; b0.cpu_we_i = we; b0.cpu_addr_i = a; b0.cpu_wdata_i = d;
  endtask

  task automatic set_ext(logic req, logic we, logic [31:0] a, logic [31:0] d);
    b0.ext_req_i = req; b0.ext_we_i = we; b0.ext_addr_i = a; b0.ext_wdata_i = d;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      busy[k] = 0; age[k] = 0; wt[k] = 0; baddr[k] = 0; chold[k] = 0; ehold[k] = 0;
      for (int i = 0; i < 256; i++) rmem[k][i] = seed(i);
    end
    set_cpu(0, 0, 0, 0);
    set_ext(0, 0, 0, 0);
    RST = 1;
    #1;
    cyc(); cyc();
    RST = 0;
    // CPU store, then load back
    set_cpu(0, 1, 32'h10, 32'hDEADBEEF);
    cyc();
    set_cpu(1, 0, 32'h10, 0);
    repeat (4) cyc();
    set_cpu(0, 0, 0, 0);
    repeat (2) cyc();
    for (int k = 0; k < 2; k++) chk("t3_load", k, o_crd[k], 32'hDEADBEEF);
    // external store then load of 0x20
    set_ext(1, 1, 32'h20, 32'h00001234);
    cyc();
    set_ext(1, 0, 32'h20, 0);
    cyc();
    set_ext(0, 0, 0, 0);
    repeat (4) cyc();
    for (int k = 0; k < 2; k++) chk("t4_load", k, o_erd[k], 32'h00001234);
    // simultaneous stores: CPU first, external the cycle after
    set_cpu(0, 1, 32'h30, 32'h00C0FFEE);
    set_ext(1, 1, 32'h31, 32'h0000BEEF);
    cyc();
    set_cpu(0, 0, 0, 0);
    cyc();
    set_ext(0, 0, 0, 0);
    cyc();
    // starvation: CPU loads continuously while external read is held
    set_cpu(1, 0, 32'h30, 0);
    set_ext(1, 0, 32'h31, 0);
    repeat (30) cyc();
    set_cpu(0, 0, 0, 0);
    set_ext(0, 0, 0, 0);
    repeat (4) cyc();
    // reset while an external read is outstanding
    set_ext(1, 0, 32'h20, 0);
    cyc();
    set_ext(0, 0, 0, 0);
    RST = 1;
    cyc(); cyc();
    RST = 0;
    for (int k = 0; k < 2; k++) chk("t1_erd_clr", k, o_erd[k], 32'h0);
    set_cpu(0, 1, 32'h05, 32'h55AA55AA);
    cyc();
    set_cpu(0, 0, 0, 0);
    repeat (4) cyc();
    // randomized traffic
    repeat (800) begin
      set_cpu($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, 32'($urandom_range(0, 15)), $urandom);
      set_ext($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 32'($urandom_range(0, 15)), $urandom);
      RST = $urandom_range(0, 63) == 0;
      cyc();
    end
    RST = 0;
    set_cpu(0, 0, 0, 0);
    set_ext(0, 0, 0, 0);
    repeat (5) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
